output_mems: RTL

- AXI-Stream transmitter for the result matrix C (M x N, row-major).
- The compute core writes C entries into an internal buffer.
- On compute_finished, the block streams all M*N words out on a master AXIS port, asserting TLAST on the final word, then signals completion back to the control logic.
- This is the output-side counterpart of the input matrix loader.

---
 rtl/output_mems.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/output_mems.sv
// AXI-Stream transmitter for the M x N result matrix C: buffers compute-core writes, then
// streams all words in address order with TLAST on the final one.
module output_mems #(
  parameter int OUTW = 28,
  parameter int M = 7,
  parameter int N = 9,
  localparam int C_ADDR_BITS = $clog2(M * N)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [OUTW-1:0]        C_wr_data,
  input  logic [C_ADDR_BITS-1:0] C_wr_addr,
  input  logic                   C_wr_en,
  input  logic                   compute_finished,
  output logic                   output_busy,
  output logic                   results_sent,
  output logic [OUTW-1:0]        AXIS_TDATA,
  output logic                   AXIS_TVALID,
  input  logic                   AXIS_TREADY,
  output logic                   AXIS_TLAST
);

  localparam int TOTAL = M * N;
  localparam logic [C_ADDR_BITS:0] TOTAL_W = (C_ADDR_BITS + 1)'(TOTAL);
  localparam logic [C_ADDR_BITS:0] LAST_W = (C_ADDR_BITS + 1)'(TOTAL - 1);

  typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

  state_e state_q, state_d;

  logic [OUTW-1:0]      mem [TOTAL];
  logic [OUTW-1:0]      mem_rdata;
  logic [C_ADDR_BITS:0] rd_ptr_q, rd_ptr_d;
  logic                 rd_vld_q, rd_vld_d;
  logic                 rd_last_q, rd_last_d;
  logic                 out_vld_q, out_vld_d;
  logic                 out_last_q, out_last_d;
  logic [OUTW-1:0]      out_data_q, out_data_d;
  logic                 skid_vld_q, skid_vld_d;
  logic                 skid_last_q, skid_last_d;
  logic [OUTW-1:0]      skid_data_q, skid_data_d;
  logic                 wr_ok, issue, pop;
  logic [1:0]           occ, occ_after;

  assign wr_ok = C_wr_en && (state_q == StIdle) && ({1'b0, C_wr_addr} < TOTAL_W);
  assign pop   = out_vld_q & AXIS_TREADY;

  // Words either buffered or in flight from the RAM; never let them exceed the two slots.
  assign occ       = {1'b0, out_vld_q} + {1'b0, skid_vld_q} + {1'b0, rd_vld_q};
  assign occ_after = occ - {1'b0, pop};
  assign issue     = (state_q == StStream) && (rd_ptr_q < TOTAL_W) && (occ_after < 2'd2);

  // Writes happen only in IDLE and reads only in STREAM, so one port suffices.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[C_wr_addr] <= C_wr_data;
    if (issue) mem_rdata <= mem[rd_ptr_q[C_ADDR_BITS-1:0]];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (compute_finished) state_d = StStream;
      StStream: if (pop && out_last_q) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    output_busy  = (state_q != StIdle);
    results_sent = (state_q == StDone);
  end

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    rd_vld_d    = issue;
    rd_last_d   = issue && (rd_ptr_q == LAST_W);
    out_vld_d   = out_vld_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    skid_vld_d  = skid_vld_q;
    skid_last_d = skid_last_q;
    skid_data_d = skid_data_q;

    if (state_q == StIdle) rd_ptr_d = '0;
    else if (issue)        rd_ptr_d = rd_ptr_q + 1'b1;

    if (pop) begin
      if (skid_vld_q) begin
        out_data_d  = skid_data_q;
        out_last_d  = skid_last_q;
        skid_vld_d  = rd_vld_q;
        skid_data_d = rd_vld_q ? mem_rdata : skid_data_q;
        skid_last_d = rd_vld_q && rd_last_q;
      end else if (rd_vld_q) begin
        out_data_d = mem_rdata;
        out_last_d = rd_last_q;
      end else begin
        out_vld_d  = 1'b0;
        out_last_d = 1'b0;
      end
    end else if (rd_vld_q) begin
      if (!out_vld_q) begin
        out_vld_d  = 1'b1;
        out_data_d = mem_rdata;
        out_last_d = rd_last_q;
      end else begin
        skid_vld_d  = 1'b1;
        skid_data_d = mem_rdata;
        skid_last_d = rd_last_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q    <= '0;
      rd_vld_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      out_vld_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      skid_vld_q  <= 1'b0;
      skid_last_q <= 1'b0;
      skid_data_q <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      rd_vld_q    <= rd_vld_d;
      rd_last_q   <= rd_last_d;
      out_vld_q   <= out_vld_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      skid_vld_q  <= skid_vld_d;
      skid_last_q <= skid_last_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign AXIS_TDATA  = out_data_q;
  assign AXIS_TVALID = out_vld_q;
  assign AXIS_TLAST  = out_last_q;

endmodule
